// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, datapath width and the result/flag payload.
package alu_pkg;

   localparam int unsigned WIDTH = 32;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_XOR  = 3'b010,
      OP_SLT  = 3'b011,
      OP_AND  = 3'b100,
      OP_NAND = 3'b101,
      OP_NOR  = 3'b110,
      OP_OR   = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             cout;
      logic             zero;
      logic             overflow;
   } alu_res_t;

   function automatic logic is_arith(input alu_op_e op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational 32-bit ALU; carry and overflow are only meaningful (non-zero) for ADD/SUB.
module ALU
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_e          op,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             overflow
);

   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             sum_ovf;
   logic             lt;

   // SUB is a + ~b + 1, so cout is the "no borrow" carry
   always_comb begin
      sub     = (op == OP_SUB);
      b_eff   = sub ? ~b : b;
      sum     = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);
      sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      lt      = $signed(a) < $signed(b);
   end

   always_comb begin
      result   = '0;
      cout     = 1'b0;
      overflow = 1'b0;
      unique case (op)
         OP_ADD, OP_SUB: begin
            result   = sum[WIDTH-1:0];
            cout     = sum[WIDTH];
            overflow = sum_ovf;
         end
         OP_XOR:  result = a ^ b;
         OP_SLT:  result = WIDTH'(lt);
         OP_AND:  result = a & b;
         OP_NAND: result = ~(a & b);
         OP_NOR:  result = ~(a | b);
         OP_OR:   result = a | b;
         default: result = '0;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage registered execute stage around ALU: S1 holds operands, S2 holds result and flags,
// with accumulate chaining, sticky overflow and a consumed-result counter.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned COUNT_W = 16
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_op,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_acc,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_result,
   output logic               out_cout,
   output logic               out_zero,
   output logic               out_overflow,
   output logic [TAG_W-1:0]   out_tag,
   input  logic               sticky_clr,
   output logic               sticky_ovf,
   output logic [COUNT_W-1:0] op_count
);

   logic               s1_valid_q, s1_valid_d;
   alu_op_e            s1_op_q, s1_op_d;
   logic [WIDTH-1:0]   s1_a_q, s1_a_d;
   logic [WIDTH-1:0]   s1_b_q, s1_b_d;
   logic               s1_acc_q, s1_acc_d;
   logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

   logic               out_valid_q, out_valid_d;
   alu_res_t           out_res_q, out_res_d;
   logic [TAG_W-1:0]   out_tag_q, out_tag_d;

   logic [WIDTH-1:0]   last_result_q, last_result_d;
   logic               sticky_q, sticky_d;
   logic [COUNT_W-1:0] op_count_q, op_count_d;

   logic [WIDTH-1:0]   alu_a;
   logic [WIDTH-1:0]   alu_result;
   logic               alu_cout;
   logic               alu_zero;
   logic               alu_overflow;
   alu_res_t           alu_res;

   logic               s2_free;
   logic               s1_move;
   logic               in_fire;
   logic               out_fire;

   assign alu_a = s1_acc_q ? last_result_q : s1_a_q;

   ALU u_alu (
      .a        (alu_a),
      .b        (s1_b_q),
      .op       (s1_op_q),
      .result   (alu_result),
      .cout     (alu_cout),
      .zero     (alu_zero),
      .overflow (alu_overflow)
   );

   // Belt-and-braces masking so only ADD/SUB ever report carry or overflow
   always_comb begin
      alu_res.result   = alu_result;
      alu_res.cout     = alu_cout && is_arith(s1_op_q);
      alu_res.zero     = alu_zero;
      alu_res.overflow = alu_overflow && is_arith(s1_op_q);
   end

   always_comb begin
      s1_valid_d    = s1_valid_q;
      s1_op_d       = s1_op_q;
      s1_a_d        = s1_a_q;
      s1_b_d        = s1_b_q;
      s1_acc_d      = s1_acc_q;
      s1_tag_d      = s1_tag_q;
      out_valid_d   = out_valid_q;
      out_res_d     = out_res_q;
      out_tag_d     = out_tag_q;
      last_result_d = last_result_q;
      sticky_d      = sticky_q;
      op_count_d    = op_count_q;

      s2_free  = !out_valid_q || out_ready;
      s1_move  = s1_valid_q && s2_free;
      in_ready = !s1_valid_q || s1_move;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid_q && out_ready;

      if (out_fire) begin
         out_valid_d = 1'b0;
         op_count_d  = op_count_q + COUNT_W'(1);
      end

      // S2 may be consumed and reloaded in the same cycle
      if (s1_move) begin
         out_valid_d   = 1'b1;
         out_res_d     = alu_res;
         out_tag_d     = s1_tag_q;
         last_result_d = alu_res.result;
         s1_valid_d    = 1'b0;
      end

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_op_d    = alu_op_e'(in_op);
         s1_a_d     = in_a;
         s1_b_d     = in_b;
         s1_acc_d   = in_acc;
         s1_tag_d   = in_tag;
      end

      // A consumed overflow beats a simultaneous clear
      if (sticky_clr) sticky_d = 1'b0;
      if (out_fire && out_res_q.overflow) sticky_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q    <= 1'b0;
         s1_op_q       <= OP_ADD;
         s1_a_q        <= '0;
         s1_b_q        <= '0;
         s1_acc_q      <= 1'b0;
         s1_tag_q      <= '0;
         out_valid_q   <= 1'b0;
         out_res_q     <= '0;
         out_tag_q     <= '0;
         last_result_q <= '0;
         sticky_q      <= 1'b0;
         op_count_q    <= '0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_op_q       <= s1_op_d;
         s1_a_q        <= s1_a_d;
         s1_b_q        <= s1_b_d;
         s1_acc_q      <= s1_acc_d;
         s1_tag_q      <= s1_tag_d;
         out_valid_q   <= out_valid_d;
         out_res_q     <= out_res_d;
         out_tag_q     <= out_tag_d;
         last_result_q <= last_result_d;
         sticky_q      <= sticky_d;
         op_count_q    <= op_count_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_result   = out_res_q.result;
   assign out_cout     = out_res_q.cout;
   assign out_zero     = out_res_q.zero;
   assign out_overflow = out_res_q.overflow;
   assign out_tag      = out_tag_q;
   assign sticky_ovf   = sticky_q;
   assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: vector table plus scoreboard queue and directed corner sequences.
module tb_alu_exec_stage;

   typedef struct packed {
      logic [31:0] r;
      logic        c;
      logic        z;
      logic        v;
      logic [3:0]  tag;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        acc;
      exp_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_acc;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_cout;
   logic        out_zero;
   logic        out_overflow;
   logic [3:0]  out_tag;
   logic        sticky_clr;
   logic        sticky_ovf;
   logic [15:0] op_count;

   alu_exec_stage #(.TAG_W(4), .COUNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .in_acc(in_acc), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_cout(out_cout), .out_zero(out_zero), .out_overflow(out_overflow), .out_tag(out_tag),
      .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf), .op_count(op_count)
   );

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   exp_cnt = 0;
   logic rnd_bp = 1'b0;
   logic [31:0] model_last = '0;
   exp_t scb[$];
   int   cons_q[$];
   vec_t tbl[14];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // Reference: plain arithmetic, borrow-free carry for SUB, overflow by 64-bit signed range
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [3:0] tag);
      exp_t        e;
      logic [32:0] w;
      longint      sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e = '0;
      e.tag = tag;
      case (op)
         3'd0: begin
            w = {1'b0, a} + {1'b0, b};
            e.r = w[31:0];
            e.c = w[32];
            s = sa + sb;
            e.v = (s != longint'($signed(e.r)));
         end
         3'd1: begin
            e.r = a - b;
            e.c = (a >= b);
            s = sa - sb;
            e.v = (s != longint'($signed(e.r)));
         end
         3'd2: e.r = a ^ b;
         3'd3: e.r = (sa < sb) ? 32'd1 : 32'd0;
         3'd4: e.r = a & b;
         3'd5: e.r = ~(a & b);
         3'd6: e.r = ~(a | b);
         default: e.r = a | b;
      endcase
      e.z = (e.r == 32'd0);
      return e;
   endfunction

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic acc, input logic [31:0] r, input logic c,
                               input logic z, input logic v, input logic [3:0] tag);
      vec_t t;
      t.op = op; t.a = a; t.b = b; t.acc = acc;
      t.exp.r = r; t.exp.c = c; t.exp.z = z; t.exp.v = v; t.exp.tag = tag;
      return t;
   endfunction

   // Scoreboard pop on every downstream consume
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (scb.size() == 0) begin
            check("unexpected_output", 64'({out_result, out_tag}), 64'hDEAD);
         end else begin
            exp_t e;
            e = scb.pop_front();
            check("result", 64'({out_result, out_cout, out_zero, out_overflow, out_tag}), 64'(e));
            cons_q.push_back(cyc);
            exp_cnt++;
         end
      end
   end

   task automatic send(input vec_t v);
      logic ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_op = v.op; in_a = v.a; in_b = v.b; in_acc = v.acc; in_tag = v.exp.tag;
      for (int i = 0; i < 50; i++) begin
         if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_ready) begin
            scb.push_back(v.exp);
            model_last = v.exp.r;
            ok = 1'b1;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!ok) fail_now("send_timeout");
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 100 && scb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      if (scb.size() != 0) fail_now("drain_timeout");
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t ovf_v;
      vec_t bp[4];
      vec_t rv;
      int   n0;
      int   sent;

      tbl[0]  = mk(3'd0, 32'h000FFFFF, 32'h1, 1'b0, 32'h00100000, 1'b0, 1'b0, 1'b0, 4'd0);
      tbl[1]  = mk(3'd0, 32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0, 4'd1);
      tbl[2]  = mk(3'd1, 32'hFFFF_0000, 32'd2, 1'b1, 32'd6, 1'b1, 1'b0, 1'b0, 4'd2);
      tbl[3]  = mk(3'd3, 32'h1234_0000, 32'd7, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 4'd3);
      tbl[4]  = mk(3'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'd4);
      tbl[5]  = mk(3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b0, 1'b0, 1'b0, 4'd5);
      tbl[6]  = mk(3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0, 4'd6);
      tbl[7]  = mk(3'd6, 32'h0F0F0000, 32'h00000F0F, 1'b0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0, 4'd7);
      tbl[8]  = mk(3'd7, 32'h12340000, 32'h00005678, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0, 4'd8);
      tbl[9]  = mk(3'd3, 32'hFFFFFFFF, 32'h1, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 4'd9);
      tbl[10] = mk(3'd3, 32'h1, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd10);
      tbl[11] = mk(3'd1, 32'h0, 32'h1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 4'd11);
      tbl[12] = mk(3'd1, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 4'd12);
      tbl[13] = mk(3'd0, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd13);
      ovf_v   = mk(3'd0, 32'hB0000000, 32'hC0000001, 1'b0, 32'h70000001, 1'b1, 1'b0, 1'b1, 4'd14);

      reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_acc = 1'b0;
      in_tag = '0; out_ready = 1'b0; sticky_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_op_count", 64'(op_count), 64'd0);
      check("rst_sticky", 64'(sticky_ovf), 64'd0);
      check("rst_out_fields", 64'({out_result, out_cout, out_zero, out_overflow, out_tag}), 64'd0);

      // Basic ADD with latency and counter
      out_ready = 1'b1;
      send(tbl[0]);
      check("lat_s1_only", 64'(out_valid), 64'd0);
      tick();
      check("lat_out_valid", 64'(out_valid), 64'd1);
      tick();
      check("op_count_1", 64'(op_count), 64'd1);

      // Back-to-back chaining
      n0 = cons_q.size();
      for (int i = 1; i <= 3; i++) send(tbl[i]);
      drain();
      if (cons_q.size() >= n0 + 3) begin
         check("chain_gap_1", 64'(cons_q[n0+1] - cons_q[n0]), 64'd1);
         check("chain_gap_2", 64'(cons_q[n0+2] - cons_q[n0+1]), 64'd1);
      end else begin
         fail_now("chain_consumes");
      end

      // Backpressure: only two transfers accepted, S2 holds the first result
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) bp[i] = tbl[4+i];
      sent = 0;
      for (int c = 0; c < 8; c++) begin
         in_valid = 1'b1;
         in_op = bp[sent].op; in_a = bp[sent].a; in_b = bp[sent].b;
         in_acc = bp[sent].acc; in_tag = bp[sent].exp.tag;
         @(negedge clk);
         if (in_ready) begin
            scb.push_back(bp[sent].exp);
            model_last = bp[sent].exp.r;
            sent++;
         end
         if (c == 4)
            check("bp_hold_mid", 64'({out_result, out_cout, out_zero, out_overflow, out_tag}),
                  64'(bp[0].exp));
         tick();
      end
      check("bp_transfers", 64'(sent), 64'd2);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_hold_end", 64'({out_result, out_cout, out_zero, out_overflow, out_tag}),
            64'(bp[0].exp));
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = sent; i < 4; i++) send(bp[i]);
      drain();

      for (int i = 8; i < 14; i++) send(tbl[i]);
      drain();

      // Sticky overflow: set, set-beats-clear, clear alone
      sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
      check("sticky_cleared", 64'(sticky_ovf), 64'd0);
      send(ovf_v);
      drain();
      tick();
      check("sticky_set", 64'(sticky_ovf), 64'd1);
      out_ready = 1'b0;
      ovf_v.exp.tag = 4'd15;
      send(ovf_v);
      tick();
      check("sticky_s2_ready", 64'(out_valid), 64'd1);
      out_ready = 1'b1; sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      check("sticky_set_wins", 64'(sticky_ovf), 64'd1);
      sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
      check("sticky_clr_alone", 64'(sticky_ovf), 64'd0);

      // Randomised traffic against the reference model
      rnd_bp = 1'b1;
      for (int i = 0; i < 24; i++) begin
         rv.op  = 3'($urandom_range(0, 7));
         rv.a   = $urandom;
         rv.b   = (i % 4 == 0) ? rv.a : $urandom;
         rv.acc = 1'($urandom_range(0, 1));
         rv.exp = model(rv.op, rv.acc ? model_last : rv.a, rv.b, 4'(i));
         send(rv);
      end
      rnd_bp = 1'b0;
      drain();
      tick();
      check("op_count_total", 64'(op_count), 64'(16'(exp_cnt)));

      // Reset with S1 and S2 both full discards everything
      out_ready = 1'b0;
      send(tbl[5]);
      send(tbl[6]);
      check("full_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b1;
      scb.delete();
      tick();
      reset = 1'b0;
      model_last = '0;
      exp_cnt = 0;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_op_count", 64'(op_count), 64'd0);
      out_ready = 1'b1;
      send(mk(3'd0, 32'h0000FFFF, 32'd9, 1'b1, 32'd9, 1'b0, 1'b0, 1'b0, 4'd9));
      drain();
      tick();
      check("post_rst_op_count", 64'(op_count), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage wrapped around the team's combinational 32-bit ALU (module ALU).
- Accepts operations over a valid/ready handshake, holds operands in stage S1 while the ALU evaluates, then captures result and flags in stage S2 for a valid/ready consumer.
- Provides result chaining (accumulate), a sticky overflow flag, and a completed-op counter.
- Sits between instruction issue and writeback.

Parameters:
- WIDTH, 32, datapath width; fixed to match ALU.
- TAG_W, 4, width of the opaque tag carried alongside each op.
- COUNT_W, 16, width of the completed-op counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream offers an op
- in_ready  out  1  stage can accept an op this cycle
- in_op  in  3  000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_acc  in  1  1 = substitute last_result for operand A
- in_tag  in  TAG_W  tag returned with the result
- out_valid  out  1  S2 holds a result
- out_ready  in  1  downstream accepts the result
- out_result  out  WIDTH  registered ALU result
- out_cout  out  1  registered carry-out
- out_zero  out  1  registered zero flag
- out_overflow  out  1  registered overflow flag
- out_tag  out  TAG_W  tag of the result
- sticky_clr  in  1  clears sticky_ovf
- sticky_ovf  out  1  set by any retired ADD/SUB with overflow
- op_count  out  COUNT_W  number of results consumed downstream

Behaviour:
- Reset, synchronous, active-high:
  - S1 and S2 valid cleared.
  - out_result, out_tag and all flags are 0.
  - last_result, sticky_ovf and op_count are 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset asserted mid-operation discards every in-flight op; there is no partial completion.
- Handshake:
  - Transfers occur on cycles where valid && ready.
  - Payload is sampled only on a transfer.
  - out_* signals are held stable while out_valid && !out_ready.
- Pipeline control:
  - s2_free = !out_valid || out_ready
  - s1_move = s1_valid && s2_free
  - in_ready = !s1_valid || s1_move
  - Full throughput is one op per cycle.
  - Latency is 2 clocks from input transfer to out_valid with no stall.
- S1 operand resolution:
  - ALU a input = last_result if s1_acc, else s1_a.
  - ALU b input = s1_b, op = s1_op.
- On s1_move:
  - S2 loads the ALU outputs and s1_tag.
  - last_result loads the ALU result.
- Flag masking:
  - For ops other than ADD and SUB, out_cout and out_overflow are forced to 0.
  - out_zero = (result == 0) for all ops.
  - SLT result is 32'd1 or 32'd0.
- Chaining semantics:
  - last_result always reflects the op immediately preceding the one in S1, because ops move in order.
  - An in_acc op issued back-to-back therefore chains correctly with no bubble.
  - last_result is updated even if downstream has not yet consumed the S2 result.
- Stall:
  - When out_valid && !out_ready, S2 holds.
  - S1 holds once filled; in_ready drops only when S1 is also full.
  - Upstream sees at most 2 outstanding ops.
- Simultaneous S2 consume and S1 move: S2 reloads in the same cycle with no bubble.
- sticky_ovf:
  - Sets on an S2 consume whose out_overflow = 1.
  - Clears on sticky_clr.
  - If both happen in the same cycle, set wins.
- op_count:
  - Increments on each out_valid && out_ready.
  - Wraps modulo 2^COUNT_W.

Decomposition:
- Shared package alu_pkg holds:
  - Op encoding constants: OP_ADD, OP_SUB, OP_XOR, OP_SLT, OP_AND, OP_NAND, OP_NOR, OP_OR.
  - WIDTH = 32.
- One sub-module: the existing ALU, instantiated once between S1 and S2.
- Pipeline registers and control stay in alu_exec_stage.

Test Plan:
- Basic ADD: reset, then ADD a=32'h000FFFFF b=1, out_ready=1.
  - Expect out_valid exactly 2 cycles after the transfer.
  - out_result=32'h00100000, cout=0, overflow=0, zero=0, op_count=1.
- Overflow and sticky: ADD a=32'hB0000000 b=32'hC0000001.
  - Expect result 32'h70000001, overflow=1, cout=1, sticky_ovf=1 after consume.
  - Then sticky_clr together with a second overflowing consume leaves sticky_ovf=1.
  - sticky_clr alone clears it.
- Back-to-back chaining, tags 1..3, out_ready=1:
  - Issue ADD a=5 b=3, then SUB acc b=2, then SLT acc b=7.
  - Expect results 8, 6, 1 on consecutive cycles.
  - Flags on the SLT result: cout=0, overflow=0.
- Backpressure: out_ready=0 while 4 ops are offered.
  - Expect in_ready=0 after 2 transfers and out_* stable.
  - Raising out_ready drains results in order, tags intact, no loss or duplication.
- Logic ops and zero flag: XOR a=b=32'hDEADBEEF.
  - Expect result 0, zero=1, cout=0, overflow=0.
- Reset mid-stream: assert reset with S1 and S2 full.
  - Next cycle: out_valid=0, in_ready=1, op_count=0, last_result=0.
  - An in_acc ADD b=9 then yields 9.
